spi_bus_sequencer: RTL and testbench
====================================

SPI_BUS_SEQUENCER -- requirements
Module: spi_bus_sequencer

Interface
REQ-001 Parameters:
- SETUP_CYCLES, default 1: cycles bus signals are stable with bus_cs_n_o high before assertion; legal range 1..15.
- CS_CYCLES, default 2: cycles bus_cs_n_o is held low; legal range 1..15.

REQ-002 Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pixel clock.
- reset_n_i  in  1  asynchronous active-low reset.
- select_i  in  1  SPI target selected.
- rx_strobe_i  in  1  one-cycle pulse, SPI byte received.
- rx_byte_i  in  8  received SPI byte.
- tx_byte_o  out  8  next SPI byte to transmit.
- bus_cs_n_o  out  1  Xosera bus select, active low.
- bus_rd_nwr_o  out  1  bus direction, 1 = read.
- bus_bytesel_o  out  1  bus byte select, 1 = odd.
- bus_reg_num_o  out  4  bus register number.
- bus_data_o  out  8  write data to Xosera.
- bus_data_i  in  8  read data from Xosera.
- soft_reset_o  out  1  one-cycle soft reset pulse.
- busy_o  out  1  bus cycle in progress.
- overrun_o  out  1  sticky, byte dropped while busy.

Function
REQ-003 Command byte format, bits 7..0: CS, WR, RS, BS, R3..R0, all active high. A packet is one command byte followed by one payload byte.

REQ-004 States are CMD, PAYLOAD, SETUP, STROBE and RECOVER. All outputs are registered.

REQ-005 CMD state, on rx_strobe_i:
- Latch the command byte.
- If RS=1: pulse soft_reset_o for exactly 1 cycle, clear overrun_o, and remain in CMD with no payload expected.
- Otherwise go to PAYLOAD.

REQ-006 PAYLOAD state, on rx_strobe_i:
- Latch rx_byte_i into the data register.
- If CS=0, return to CMD; no bus cycle is issued.
- If CS=1, go to SETUP.

REQ-007 SETUP state: drive bus_reg_num_o=R3..R0, bus_bytesel_o=BS, bus_rd_nwr_o=~WR, bus_data_o=payload, with bus_cs_n_o=1, for SETUP_CYCLES cycles, then go to STROBE.

REQ-008 STROBE state: bus_cs_n_o=0 for CS_CYCLES cycles. On a read, capture bus_data_i into rd_data_q on the last STROBE cycle, then go to RECOVER.

REQ-009 RECOVER state: bus_cs_n_o=1 for 1 cycle, then go to CMD. Address, direction and data hold their values through RECOVER.

REQ-010 Latency with default parameters, payload strobe at cycle T:
- SETUP at T+1.
- bus_cs_n_o low during T+2 and T+3.
- RECOVER at T+4.
- CMD (accepting bytes) at T+5.

REQ-011 busy_o=1 exactly in SETUP, STROBE and RECOVER.

REQ-012 tx_byte_o = rd_data_q in CMD state, and 8'hCB in all other states. Read data from packet N is therefore shifted out during the command byte of packet N+1.

REQ-013 Boundary conditions:
- rx_strobe_i while busy_o=1: drop the byte (including RS commands) and set overrun_o.
- select_i low in PAYLOAD: abort the partial packet and return to CMD.
- select_i low in SETUP, STROBE or RECOVER: no effect; the bus cycle completes.
- rx_strobe_i and select_i low in the same cycle: the strobe takes priority.

REQ-014 overrun_o clears only on an RS command or on reset.

Reset
REQ-015 While reset_n_i=0, asynchronously force:
- state=CMD, bus_cs_n_o=1, bus_rd_nwr_o=1, bus_bytesel_o=0, bus_reg_num_o=0, bus_data_o=0;
- rd_data_q=0, so tx_byte_o=8'h00;
- soft_reset_o=0, busy_o=0, overrun_o=0; counters=0.

REQ-016 Reset asserted mid-bus-cycle immediately deasserts bus_cs_n_o (drives it to 1). No partial strobe resumes after release.

REQ-017 soft_reset_o does not reset this block.

Structure
REQ-018 Package xv holds:
- command bit-position constants;
- the state enum typedef;
- the status byte constant 8'hCB.

REQ-019 A single flat module with no sub-module. One 4-bit down-counter is shared by SETUP and STROBE.

Verification
REQ-020 Write packet 8'hC3, 8'h5A, defaults -> SETUP with bus_cs_n_o=1, bus_reg_num_o=3, bus_rd_nwr_o=0, bus_data_o=8'h5A; bus_cs_n_o low exactly 2 cycles at T+2..T+3; busy_o low at T+5.

REQ-021 Read packet 8'h92, 8'h00 with bus_data_i=8'hA7 -> bus_bytesel_o=1, bus_rd_nwr_o=1; tx_byte_o=8'hA7 after return to CMD; tx_byte_o=8'hCB in PAYLOAD.

REQ-022 Command 8'h20 -> soft_reset_o high 1 cycle; no bus_cs_n_o assertion; next byte is treated as a command.

REQ-023 Byte strobed at T+2 of a write -> dropped, overrun_o=1, bus cycle unaffected; later 8'h20 -> overrun_o=0.

REQ-024 Command 8'hC0, then select_i low before payload -> state CMD, no bus cycle; next 2-byte packet executes normally.

REQ-025 reset_n_i low during STROBE -> bus_cs_n_o=1 in the same cycle, all outputs at reset values; first packet after release executes correctly.

Source files
------------

// File: rtl/spi_bus_sequencer_pkg.sv
// Shared definitions for the SPI-to-Xosera bus sequencer: command bit
// positions, sequencer states and the status byte returned while busy.
package xv;

    localparam int CMD_CS = 7;
    localparam int CMD_WR = 6;
    localparam int CMD_RS = 5;
    localparam int CMD_BS = 4;

    localparam logic [7:0] STATUS_BYTE = 8'hCB;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_PAYLOAD,
        ST_SETUP,
        ST_STROBE,
        ST_RECOVER
    } state_e;

endpackage

// File: rtl/spi_bus_sequencer.sv
// Turns two-byte SPI packets (command + payload) into one timed Xosera bus
// cycle: setup with select high, a select-low strobe, then one recovery cycle.
module spi_bus_sequencer
    import xv::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int CS_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic       select_i,
    input  logic       rx_strobe_i,
    input  logic [7:0] rx_byte_i,
    output logic [7:0] tx_byte_o,
    output logic       bus_cs_n_o,
    output logic       bus_rd_nwr_o,
    output logic       bus_bytesel_o,
    output logic [3:0] bus_reg_num_o,
    output logic [7:0] bus_data_o,
    input  logic [7:0] bus_data_i,
    output logic       soft_reset_o,
    output logic       busy_o,
    output logic       overrun_o
);

    // Counter reload values: a load of N-1 gives N cycles in the state.
    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] CS_LOAD    = 4'(CS_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    // Command fields kept without RS: {CS, WR, BS, R3..R0}
    logic [6:0] cmd_q, cmd_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [7:0] tx_q, tx_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_nwr_q, rd_nwr_d;
    logic       bytesel_q, bytesel_d;
    logic [3:0] reg_num_q, reg_num_d;
    logic [7:0] data_q, data_d;
    logic       soft_q, soft_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        rd_data_d = rd_data_q;
        rd_nwr_d  = rd_nwr_q;
        bytesel_d = bytesel_q;
        reg_num_d = reg_num_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        soft_d    = 1'b0;

        case (state_q)
            ST_CMD: begin
                if (rx_strobe_i) begin
                    cmd_d = {rx_byte_i[CMD_CS], rx_byte_i[CMD_WR],
                             rx_byte_i[CMD_BS], rx_byte_i[3:0]};
                    if (rx_byte_i[CMD_RS]) begin
                        soft_d    = 1'b1;
                        overrun_d = 1'b0;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                // A strobe wins over a simultaneous deselect.
                if (rx_strobe_i) begin
                    data_d = rx_byte_i;
                    if (cmd_q[6]) begin
                        state_d   = ST_SETUP;
                        cnt_d     = SETUP_LOAD;
                        rd_nwr_d  = ~cmd_q[5];
                        bytesel_d = cmd_q[4];
                        reg_num_d = cmd_q[3:0];
                    end else begin
                        state_d = ST_CMD;
                    end
                end else if (!select_i) begin
                    state_d = ST_CMD;
                end
            end
            ST_SETUP: begin
                if (rx_strobe_i) overrun_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = CS_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (rx_strobe_i) overrun_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_RECOVER;
                    if (rd_nwr_q) rd_data_d = bus_data_i;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RECOVER: begin
                if (rx_strobe_i) overrun_d = 1'b1;
                state_d = ST_CMD;
            end
            default: state_d = ST_CMD;
        endcase

        // Outputs are registered from the next state so they line up with it.
        cs_n_d = (state_d != ST_STROBE);
        busy_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                 (state_d == ST_RECOVER);
        tx_d   = (state_d == ST_CMD) ? rd_data_d : STATUS_BYTE;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_CMD;
            cnt_q     <= 4'd0;
            cmd_q     <= 7'd0;
            rd_data_q <= 8'h00;
            tx_q      <= 8'h00;
            cs_n_q    <= 1'b1;
            rd_nwr_q  <= 1'b1;
            bytesel_q <= 1'b0;
            reg_num_q <= 4'd0;
            data_q    <= 8'h00;
            soft_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            rd_data_q <= rd_data_d;
            tx_q      <= tx_d;
            cs_n_q    <= cs_n_d;
            rd_nwr_q  <= rd_nwr_d;
            bytesel_q <= bytesel_d;
            reg_num_q <= reg_num_d;
            data_q    <= data_d;
            soft_q    <= soft_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign tx_byte_o     = tx_q;
    assign bus_cs_n_o    = cs_n_q;
    assign bus_rd_nwr_o  = rd_nwr_q;
    assign bus_bytesel_o = bytesel_q;
    assign bus_reg_num_o = reg_num_q;
    assign bus_data_o    = data_q;
    assign soft_reset_o  = soft_q;
    assign busy_o        = busy_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_spi_bus_sequencer.sv
// Bench for spi_bus_sequencer: a cycle-indexed packet model checked every
// cycle, plus directed packets with hand-computed expectations.
module tb_spi_bus_sequencer;

    localparam int S = 1;
    localparam int C = 2;

    logic       clk = 1'b0;
    logic       reset_n_i;
    logic       select_i;
    logic       rx_strobe_i;
    logic [7:0] rx_byte_i;
    logic [7:0] tx_byte_o;
    logic       bus_cs_n_o;
    logic       bus_rd_nwr_o;
    logic       bus_bytesel_o;
    logic [3:0] bus_reg_num_o;
    logic [7:0] bus_data_o;
    logic [7:0] bus_data_i;
    logic       soft_reset_o;
    logic       busy_o;
    logic       overrun_o;

    int checks = 0;
    int errors = 0;

    spi_bus_sequencer #(.SETUP_CYCLES(S), .CS_CYCLES(C)) dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .select_i     (select_i),
        .rx_strobe_i  (rx_strobe_i),
        .rx_byte_i    (rx_byte_i),
        .tx_byte_o    (tx_byte_o),
        .bus_cs_n_o   (bus_cs_n_o),
        .bus_rd_nwr_o (bus_rd_nwr_o),
        .bus_bytesel_o(bus_bytesel_o),
        .bus_reg_num_o(bus_reg_num_o),
        .bus_data_o   (bus_data_o),
        .bus_data_i   (bus_data_i),
        .soft_reset_o (soft_reset_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a bus cycle is a window of cycles starting at m_start (the cycle
    // after the payload strobe): S setup cycles, C strobe cycles, 1 recovery.
    int         m_cyc;
    int         m_start;
    bit         m_expect_pl;
    logic [7:0] m_cmd;
    logic       m_ovr, m_soft, m_rdnwr, m_bs;
    logic [7:0] m_rd, m_data;
    logic [3:0] m_reg;
    logic       e_busy, e_csn;
    logic [7:0] e_tx;

    always @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_cyc = 0; m_start = -1; m_expect_pl = 0; m_cmd = 0;
            m_ovr = 0; m_soft = 0; m_rd = 0; m_data = 0;
            m_reg = 0; m_bs = 0; m_rdnwr = 1;
        end else begin
            m_soft = 0;
            if (m_start >= 0 && m_cyc >= m_start) begin
                if (rx_strobe_i) m_ovr = 1;
                if (m_cyc == m_start + S + C - 1 && m_rdnwr) m_rd = bus_data_i;
                if (m_cyc == m_start + S + C) m_start = -1;
            end else if (m_expect_pl) begin
                if (rx_strobe_i) begin
                    m_data = rx_byte_i;
                    m_expect_pl = 0;
                    if (m_cmd[7]) begin
                        m_start = m_cyc + 1;
                        m_rdnwr = ~m_cmd[6];
                        m_bs    = m_cmd[4];
                        m_reg   = m_cmd[3:0];
                    end
                end else if (!select_i) begin
                    m_expect_pl = 0;
                end
            end else if (rx_strobe_i) begin
                if (rx_byte_i[5]) begin
                    m_soft = 1;
                    m_ovr  = 0;
                end else begin
                    m_cmd = rx_byte_i;
                    m_expect_pl = 1;
                end
            end
            m_cyc++;
        end
        e_busy = (m_start >= 0 && m_cyc >= m_start);
        e_csn  = !(m_start >= 0 && m_cyc >= m_start + S && m_cyc <= m_start + S + C - 1);
        e_tx   = (!e_busy && !m_expect_pl) ? m_rd : 8'hCB;
    end

    always @(negedge clk) begin
        chk("model_busy", busy_o, e_busy);
        chk("model_cs_n", bus_cs_n_o, e_csn);
        chk("model_tx", tx_byte_o, e_tx);
        chk("model_soft", soft_reset_o, m_soft);
        chk("model_overrun", overrun_o, m_ovr);
        if (e_busy) begin
            chk("model_reg", bus_reg_num_o, m_reg);
            chk("model_bytesel", bus_bytesel_o, m_bs);
            chk("model_rd_nwr", bus_rd_nwr_o, m_rdnwr);
            chk("model_data", bus_data_o, m_data);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_strobe_i = 1'b1;
        rx_byte_i   = b;
        @(negedge clk);
        rx_strobe_i = 1'b0;
    endtask

    task automatic send_nosel(input logic [7:0] b);
        @(negedge clk);
        rx_strobe_i = 1'b1;
        rx_byte_i   = b;
        select_i    = 1'b0;
        @(negedge clk);
        rx_strobe_i = 1'b0;
        select_i    = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", busy_o, 1'b0);
    endtask

    initial begin
        reset_n_i = 1'b0; select_i = 1'b1; rx_strobe_i = 1'b0;
        rx_byte_i = 8'h00; bus_data_i = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_byte_o, 8'h00);
        chk("rst_cs_n", bus_cs_n_o, 1'b1);
        chk("rst_rd_nwr", bus_rd_nwr_o, 1'b1);
        chk("rst_bytesel", bus_bytesel_o, 1'b0);
        chk("rst_reg", bus_reg_num_o, 4'h0);
        chk("rst_data", bus_data_o, 8'h00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_overrun", overrun_o, 1'b0);
        reset_n_i = 1'b1;
        @(negedge clk);

        // Write C3,5A: returns in T+1
        send(8'hC3); send(8'h5A);
        chk("wr_setup_busy", busy_o, 1'b1);
        chk("wr_setup_cs_n", bus_cs_n_o, 1'b1);
        chk("wr_setup_reg", bus_reg_num_o, 4'h3);
        chk("wr_setup_rd_nwr", bus_rd_nwr_o, 1'b0);
        chk("wr_setup_data", bus_data_o, 8'h5A);
        @(negedge clk); chk("wr_t2_cs_n", bus_cs_n_o, 1'b0);
        @(negedge clk); chk("wr_t3_cs_n", bus_cs_n_o, 1'b0);
        @(negedge clk); chk("wr_t4_cs_n", bus_cs_n_o, 1'b1);
        chk("wr_t4_busy", busy_o, 1'b1);
        @(negedge clk); chk("wr_t5_busy", busy_o, 1'b0);

        // Read 92,00 with bus data A7
        bus_data_i = 8'hA7;
        send(8'h92);
        chk("rd_payload_tx", tx_byte_o, 8'hCB);
        send(8'h00);
        chk("rd_bytesel", bus_bytesel_o, 1'b1);
        chk("rd_rd_nwr", bus_rd_nwr_o, 1'b1);
        chk("rd_reg", bus_reg_num_o, 4'h2);
        repeat (4) @(negedge clk);
        chk("rd_t5_busy", busy_o, 1'b0);
        chk("rd_tx", tx_byte_o, 8'hA7);
        bus_data_i = 8'h3C;

        // Soft reset command, then a packet treated normally
        send(8'h20);
        chk("rs_soft", soft_reset_o, 1'b1);
        chk("rs_tx", tx_byte_o, 8'hA7);
        @(negedge clk); chk("rs_soft_end", soft_reset_o, 1'b0);
        send(8'hC3); send(8'h5A);
        chk("rs_next_busy", busy_o, 1'b1);
        wait_idle();

        // Byte strobed at T+2 is dropped and flags overrun
        send(8'hC1); send(8'h77); send(8'hEE);
        chk("ovr_set", overrun_o, 1'b1);
        chk("ovr_t3_cs_n", bus_cs_n_o, 1'b0);
        chk("ovr_data", bus_data_o, 8'h77);
        wait_idle();
        chk("ovr_sticky", overrun_o, 1'b1);
        send(8'h20);
        chk("ovr_clear", overrun_o, 1'b0);

        // Deselect in PAYLOAD aborts the packet
        send(8'hC0);
        @(negedge clk); select_i = 1'b0;
        @(negedge clk); select_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_tx", tx_byte_o, 8'hA7);
        send(8'hC3); send(8'h5A);
        chk("abort_next_busy", busy_o, 1'b1);
        @(negedge clk); chk("abort_next_cs_n", bus_cs_n_o, 1'b0);
        wait_idle();

        // Strobe wins over simultaneous deselect
        send(8'hC2); send_nosel(8'h66);
        chk("prio_busy", busy_o, 1'b1);
        chk("prio_data", bus_data_o, 8'h66);
        wait_idle();

        // Reset during STROBE
        send(8'hC4); send(8'h99);
        @(negedge clk); chk("rstmid_cs_low", bus_cs_n_o, 1'b0);
        #1 reset_n_i = 1'b0;
        #1;
        chk("rstmid_cs_n", bus_cs_n_o, 1'b1);
        chk("rstmid_busy", busy_o, 1'b0);
        chk("rstmid_tx", tx_byte_o, 8'h00);
        chk("rstmid_data", bus_data_o, 8'h00);
        chk("rstmid_rd_nwr", bus_rd_nwr_o, 1'b1);
        @(negedge clk);
        @(negedge clk); reset_n_i = 1'b1;
        @(negedge clk); chk("rstrel_cs_n", bus_cs_n_o, 1'b1);
        send(8'hC3); send(8'h5A);
        chk("rstrel_busy", busy_o, 1'b1);
        chk("rstrel_reg", bus_reg_num_o, 4'h3);
        chk("rstrel_data", bus_data_o, 8'h5A);
        @(negedge clk); chk("rstrel_cs_low", bus_cs_n_o, 1'b0);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
